// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-lite initiator.
// Turns one command from a simple valid/ready command port into an AXI-lite
// read or write, and returns the bus response on a valid/ready response port.
// A bus phase that stalls for TIMEOUT cycles is abandoned and reported as
// SLVERR (2'b10). TIMEOUT = 0 disables the abort.
//
// Ports:
//   a_clk, a_rst                      clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command in
//   rsp_valid/ready/rdata/resp        response out
//   aw_*, w_*, b_*                    AXI-lite write channels
//   ar_*, r_*                         AXI-lite read channels
// Every output is a flop; all of them read 0 while in reset.
module axi_lite_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic        PROT    = 1'b0
) (
  input  logic         a_clk,
  input  logic         a_rst,
  // command port
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [17:0]  cmd_addr,
  input  logic [15:0]  cmd_wdata,
  input  logic [1:0]   cmd_wstrb,
  // response port
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [15:0]  rsp_rdata,
  output logic [1:0]   rsp_resp,
  // write address channel
  output logic         aw_valid,
  input  logic         aw_ready,
  output logic [17:0]  aw_addr,
  output logic         aw_prot,
  // write data channel
  output logic         w_valid,
  input  logic         w_ready,
  output logic [15:0]  w_data,
  output logic [1:0]   w_strb,
  // write response channel
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [1:0]   b_resp,
  // read address channel
  output logic         ar_valid,
  input  logic         ar_ready,
  output logic [17:0]  ar_addr,
  output logic         ar_prot,
  // read data channel
  input  logic         r_valid,
  output logic         r_ready,
  input  logic [15:0]  r_data,
  input  logic [1:0]   r_resp
);

  localparam int unsigned AW       = 18;
  localparam int unsigned DW       = 16;
  localparam int unsigned SW       = 2;
  localparam int unsigned RW       = 2;
  localparam int unsigned CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Count value during the last allowed cycle of a phase.
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [RW-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RW-1:0] rsp_resp_q,  rsp_resp_d;
  logic          aw_valid_q,  aw_valid_d;
  logic [AW-1:0] aw_addr_q,   aw_addr_d;
  logic          prot_q,      prot_d;
  logic          w_valid_q,   w_valid_d;
  logic [DW-1:0] w_data_q,    w_data_d;
  logic [SW-1:0] w_strb_q,    w_strb_d;
  logic          b_ready_q,   b_ready_d;
  logic          ar_valid_q,  ar_valid_d;
  logic [AW-1:0] ar_addr_q,   ar_addr_d;
  logic          r_ready_q,   r_ready_d;

  // Phase has used up its last allowed cycle.
  logic expire_c;
  assign expire_c = TMO_EN && (cnt_q == CW'(TMO_LAST));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_valid_d  = aw_valid_q;
    aw_addr_d   = aw_addr_q;
    prot_d      = PROT;
    w_valid_d   = w_valid_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    ar_addr_d   = ar_addr_q;
    r_ready_d   = r_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_write) begin
            aw_addr_d  = cmd_addr;
            w_data_d   = cmd_wdata;
            w_strb_d   = cmd_wstrb;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            b_ready_d  = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            ar_addr_d  = cmd_addr;
            ar_valid_d = 1'b1;
            r_ready_d  = 1'b1;
            state_d    = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        cnt_d = cnt_q + CW'(1);
        if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
        // A completion on the expiry edge takes priority over the abort.
        if (b_valid && b_ready_q) begin
          rsp_resp_d  = b_resp;
          rsp_rdata_d = '0;
          aw_valid_d  = 1'b0;
          w_valid_d   = 1'b0;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (expire_c) begin
          rsp_resp_d  = RESP_SLVERR;
          rsp_rdata_d = '0;
          aw_valid_d  = 1'b0;
          w_valid_d   = 1'b0;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_READ: begin
        cnt_d = cnt_q + CW'(1);
        if (ar_valid_q && ar_ready) ar_valid_d = 1'b0;
        if (r_valid && r_ready_q) begin
          rsp_resp_d  = r_resp;
          rsp_rdata_d = r_data;
          ar_valid_d  = 1'b0;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (expire_c) begin
          rsp_resp_d  = RESP_SLVERR;
          rsp_rdata_d = '0;
          ar_valid_d  = 1'b0;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      prot_q      <= 1'b0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      prot_q      <= prot_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      r_ready_q   <= r_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign aw_valid  = aw_valid_q;
  assign aw_addr   = aw_addr_q;
  assign aw_prot   = prot_q;
  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;
  assign w_strb    = w_strb_q;
  assign b_ready   = b_ready_q;
  assign ar_valid  = ar_valid_q;
  assign ar_addr   = ar_addr_q;
  assign ar_prot   = prot_q;
  assign r_ready   = r_ready_q;

endmodule
